// File: rtl/bcd_pkg.sv
// Shared constants for the binary-to-BCD converter: FSM states and the
// double-dabble correction parameters.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_FIN   = 2'd3
    } bcd_state_e;

    localparam logic [3:0] ADD3_THRESHOLD  = 4'd4;
    localparam logic [3:0] ADD3_CORRECTION = 4'd3;

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the double-dabble chain: pre-shift add-3 correction,
// then shift left by one with the serial input entering the LSB.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       shift_en,
    input  logic       in,
    output logic [3:0] digit,
    output logic       carry_out
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;
    logic [3:0] corr;

    always_comb begin
        corr    = (digit_q > ADD3_THRESHOLD) ? digit_q + ADD3_CORRECTION : digit_q;
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (shift_en) begin
            digit_d = {corr[2:0], in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    // Bit leaving this digit on the shift; feeds the next digit's LSB.
    assign carry_out = corr[3];

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter: one bit per cycle through a chain of
// digit cells, saturating to all nines with ovf when the operand is too large.
module bcd_convert_ctrl
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    bcd_state_e          state_q, state_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sticky_q, sticky_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    logic [4*DIGITS-1:0] digits_w;
    logic [4*DIGITS-1:0] nines;
    logic [DIGITS-1:0]   carry;
    logic [DIGITS-1:0]   chain_in;
    logic                shift_en;
    logic                clr;

    assign shift_en = (state_q == ST_SHIFT);
    assign clr      = (state_q == ST_LOAD);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        if (g == 0) begin : g_first
            assign chain_in[g] = shreg_q[WIDTH-1];
        end else begin : g_rest
            assign chain_in[g] = carry[g-1];
        end

        bcd_digit_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .shift_en  (shift_en),
            .in        (chain_in[g]),
            .digit     (digits_w[4*g +: 4]),
            .carry_out (carry[g])
        );
    end

    always_comb begin
        nines = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            nines[4*i +: 4] = 4'd9;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d = bin;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d    = CNT_W'(WIDTH);
                sticky_d = 1'b0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (carry[DIGITS-1]) begin
                    sticky_d = 1'b1;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                bcd_d   = sticky_q ? nines : digits_w;
                ovf_d   = sticky_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign done  = done_q;
    assign bcd   = bcd_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Scoreboard bench for bcd_convert_ctrl: the driver queues expected results,
// a monitor pops and compares on every done pulse.
module tb_bcd_convert_ctrl;

    localparam int W = 10;
    localparam int D = 3;
    localparam int unsigned LAT = W + 2;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   bin;
    logic           ready;
    logic           done;
    logic [4*D-1:0] bcd;
    logic           ovf;

    typedef struct {
        logic [4*D-1:0] bcd;
        logic           ovf;
        int unsigned    cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          checks;
    int          failures;

    bcd_convert_ctrl #(.WIDTH(W), .DIGITS(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 bcd=%h at cycle %0d, required no done", bcd, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (bcd !== e.bcd) begin
                    failures++;
                    $display("FAIL bcd: got %h, required %h", bcd, e.bcd);
                end
                checks++;
                if (ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL ovf: got %b, required %b (bcd %h)", ovf, e.ovf, e.bcd);
                end
                checks++;
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL latency: done at cycle %0d, required cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic check_vec(input string name, input logic [4*D-1:0] got, input logic [4*D-1:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Issue one start pulse; caller must be at a negedge with ready expected high.
    task automatic issue(input logic [W-1:0] v, input logic [4*D-1:0] eb, input logic eo);
        exp_t e;
        bin   = v;
        start = 1'b1;
        e.bcd = eb;
        e.ovf = eo;
        e.cyc = cyc + 1 + LAT;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic convert(input logic [W-1:0] v, input logic [4*D-1:0] eb, input logic eo);
        issue(v, eb, eo);
        wait_drain();
        @(negedge clk);
    endtask

    initial begin
        int unsigned e0;
        int n;
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        check_bit("reset_ready", ready, 1'b1);
        check_bit("reset_done", done, 1'b0);
        check_bit("reset_ovf", ovf, 1'b0);
        check_vec("reset_bcd", bcd, 12'h000);
        rst = 1'b0;

        // First start on the first edge after reset release
        convert(10'd0, 12'h000, 1'b0);
        convert(10'd255, 12'h255, 1'b0);
        convert(10'd999, 12'h999, 1'b0);
        convert(10'd1000, 12'h999, 1'b1);
        convert(10'd1023, 12'h999, 1'b1);
        convert(10'd9, 12'h009, 1'b0);

        // Re-pulse during SHIFT with a new operand: must be ignored
        issue(10'd300, 12'h300, 1'b0);
        repeat (3) @(negedge clk);
        bin   = 10'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_vec("hold_bcd_during_shift", bcd, 12'h009);
        wait_drain();
        repeat (15) @(negedge clk);
        check_bit("no_queued_start_ready", ready, 1'b1);

        // Reset at SHIFT cycle 5 aborts without done
        bin   = 10'd500;
        start = 1'b1;
        e0    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e0 + 5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_bit("abort_ready", ready, 1'b1);
        check_bit("abort_done", done, 1'b0);
        check_vec("abort_bcd", bcd, 12'h000);
        check_bit("abort_ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        convert(10'd42, 12'h042, 1'b0);

        // start held high: one conversion every W+3 cycles
        bin   = 10'd128;
        start = 1'b1;
        e0    = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.bcd = 12'h128;
            e.ovf = 1'b0;
            e.cyc = e0 + k * (LAT + 1) + LAT;
            sb.push_back(e);
        end
        n = 0;
        while (cyc < e0 + 2 * (LAT + 1) + LAT && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        wait_drain();
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
